pe_matrix_expectation_seq: RTL

PE_MATRIX_EXPECTATION_SEQ -- requirements
Module: pe_matrix_expectation_seq

---
 rtl/pe_matrix_pkg.sv | 15 +
 rtl/pe_expectation_lane.sv | 67 ++++++
 rtl/pe_matrix_expectation_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/pe_matrix_pkg.sv
// Shared state encoding and default sizing for the sigma-point expectation engine.
package pe_matrix_pkg;

    localparam int PE_DIM_DEFAULT    = 5;
    localparam int PE_N_DEFAULT      = 11;
    localparam int PE_DATA_W_DEFAULT = 32;
    localparam int PE_ACC_W_DEFAULT  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } pe_state_e;

endpackage

// File: rtl/pe_expectation_lane.sv
// One lane of the weighted sigma-point sum: acc = sum(weight * sigma_i).
// PE_EXPECT_SATURATE_EN selects clamping with a sticky overflow flag; otherwise sums wrap.
module pe_expectation_lane #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_acc,
    input  logic [DATA_W-1:0] i_weight,
    input  logic [DATA_W-1:0] i_sigma,
    output logic [ACC_W-1:0]  o_acc,
    output logic              o_ovf
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]           w_sum;
    logic [ACC_W-1:0]           r_acc;

    assign w_prod     = $signed(i_weight) * $signed(i_sigma);
    assign w_prod_ext = ACC_W'(w_prod);

`ifdef PE_EXPECT_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_sum_wide;
    logic           w_over;
    logic           r_ovf;

    // One guard bit: the two top bits disagree exactly when the signed sum overflowed.
    assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
    assign w_over     = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
    assign w_sum      = w_over ? (w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                               : w_sum_wide[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || i_clear || i_load) begin
            r_ovf <= 1'b0;
        end else if (i_acc && w_over) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`else
    assign w_sum = r_acc + w_prod_ext;
    assign o_ovf = 1'b0;
`endif

    // A first pair cannot overflow since ACC_W >= 2*DATA_W, so load is a plain copy.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_prod_ext;
        end else if (i_acc) begin
            r_acc <= w_sum;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/pe_matrix_expectation_seq.sv
// Sequential expectation engine: accumulates N_SIGMA weighted sigma points across
// DIM_SIGMA lanes, then holds the result until taken. Option: PE_EXPECT_SATURATE_EN.
module pe_matrix_expectation_seq
    import pe_matrix_pkg::*;
#(
    parameter int DIM_SIGMA = PE_DIM_DEFAULT,
    parameter int N_SIGMA   = PE_N_DEFAULT,
    parameter int DATA_W    = PE_DATA_W_DEFAULT,
    parameter int ACC_W     = PE_ACC_W_DEFAULT,
    localparam int CNT_W    = $clog2(N_SIGMA + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          weight,
    input  logic [DATA_W*DIM_SIGMA-1:0] sigma,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W*DIM_SIGMA-1:0] mac_out,
    output logic [CNT_W-1:0]           count,
    output logic                       ovf,
    output pe_state_e                  o_dbg_state
);

    // Handshake: a pair moves on any rising edge where in_valid && in_ready; a result
    // moves where out_valid && out_ready. flush/rst override both for that edge.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SIGMA - 1);

    pe_state_e             r_state;
    pe_state_e             w_state_nxt;
    logic [CNT_W-1:0]      r_count;
    logic                  w_xfer;
    logic                  w_load;
    logic                  w_acc;
    logic [DIM_SIGMA-1:0]  w_lane_ovf;

    assign w_xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_xfer) w_state_nxt = ST_ACCUM;
                ST_ACCUM: if (w_xfer && (r_count == LAST_IDX)) w_state_nxt = ST_DONE;
                ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state != ST_DONE);
        out_valid = (r_state == ST_DONE);
        w_load    = w_xfer && (r_state == ST_IDLE) && !flush;
        w_acc     = w_xfer && (r_state == ST_ACCUM) && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= CNT_W'(1);
        end else if (w_acc) begin
            r_count <= r_count + CNT_W'(1);
        end else if ((r_state == ST_DONE) && out_ready) begin
            r_count <= '0;
        end
    end

    for (genvar g = 0; g < DIM_SIGMA; g++) begin : g_lane
        pe_expectation_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (flush),
            .i_load   (w_load),
            .i_acc    (w_acc),
            .i_weight (weight),
            .i_sigma  (sigma[DATA_W*g +: DATA_W]),
            .o_acc    (mac_out[ACC_W*g +: ACC_W]),
            .o_ovf    (w_lane_ovf[g])
        );
    end

    assign ovf         = |w_lane_ovf;
    assign count       = r_count;
    assign o_dbg_state = r_state;

endmodule
